unidir_stream_fifo: RTL
=======================

# unidir_stream_fifo

Parametrised stream buffer joining a unidirectional producer (inputs-only sink side) to a unidirectional consumer (outputs-only source side). It generalises a fixed 8-bit valid/data path to configurable width and depth, adds ready backpressure on both sides, and adds an optional drop-on-full mode with a saturating drop counter. It sits between a data source and a sink block inside a top-level wrapper.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, entries; power of two, >=2
- DROP_ON_FULL, 0, 0 = backpressure via in_ready; 1 = in_ready tied high, words arriving while full are discarded
- CNT_W, 8, width of drop counter
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- flush  input  1  synchronous clear of contents and drop counter
- data_in  input  WIDTH  write data
- in_valid  input  1  write request
- in_ready  output  1  write accept
- valid  output  1  read data available
- data_out  output  WIDTH  head-of-queue data
- out_ready  input  1  consumer accepts head word
- level  output  $clog2(DEPTH)+1  current occupancy
- drop_cnt  output  CNT_W  words discarded (DROP_ON_FULL=1 only), saturating

## Operation
- Storage: DEPTH x WIDTH register array; rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits (extra wrap bit); full = MSBs differ and lower bits equal; empty = pointers equal.
- level = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- in_ready = !full when DROP_ON_FULL=0; constant 1 when DROP_ON_FULL=1.
- push = in_valid & !full; pop = valid & out_ready.
- valid = !empty; data_out = mem[rd_ptr] when valid, else all zeros (show-ahead, no stale data).
- full/empty are evaluated from the pre-edge state: a push while full is refused (DROP_ON_FULL=0) or dropped (DROP_ON_FULL=1) even if a pop occurs in the same cycle.
- Push and pop in the same cycle when neither full nor empty: both proceed; level unchanged.
- Drop: DROP_ON_FULL=1 and in_valid & full -> drop_cnt += 1, saturating at 2^CNT_W-1; data not stored. With DROP_ON_FULL=0 drop_cnt stays 0.
- flush: next edge sets rd_ptr = wr_ptr = 0 and drop_cnt = 0; overrides push, pop and drop in that cycle.
- Pointer wrap: lower bits wrap to 0 after DEPTH-1; the wrap bit toggles.

## Timing
- Reset (rst_n low, asynchronous): pointers 0, drop_cnt 0. Outputs: valid 0, data_out 0, level 0, in_ready 1.
- Reset deasserted mid-stream: contents are lost and no partial word is emitted.
- Write-to-read latency: a word pushed at edge N appears on valid/data_out after edge N (i.e. in cycle N+1). There is no combinational path from in_valid to valid.
- Pop takes effect at the edge where valid & out_ready. The next word, if any, is presented in the following cycle, so back-to-back throughput is 1 word/cycle.
- in_ready depends only on state (no combinational path from out_ready).
- level, drop_cnt: registered or derived only from registers; they update one edge after the event.

## Test plan
- Reset, WIDTH=8, DEPTH=4: assert rst_n=0 mid-cycle -> immediately valid=0, data_out=0x00, level=0, in_ready=1, drop_cnt=0.
- Fill and drain: push 0x11,0x22,0x33,0x44 with out_ready=0 -> level=4, in_ready=0 (DROP_ON_FULL=0). Fifth word 0x55 is held off. Then out_ready=1 -> data_out 0x11,0x22,0x33,0x44 on consecutive cycles, then valid=0, data_out=0.
- Simultaneous push/pop at level 2 over 10 cycles with incrementing data -> level stays 2, output order is preserved, and pointers wrap twice without corruption.
- Full plus push plus pop (DEPTH=4, full): in_valid=1, out_ready=1 -> pop occurs, push refused, level=3. The next cycle push is accepted, level=4.
- DROP_ON_FULL=1, CNT_W=2: fill to 4, then present 5 more words while out_ready=0 -> in_ready=1 throughout, drop_cnt saturates at 3, and drained data equals the first 4 words.
- flush at level 3 with push and pop also asserted -> next cycle level=0, valid=0, drop_cnt=0. A push in the following cycle is seen on valid one cycle later.

Source files
------------

// File: rtl/unidir_stream_fifo.sv
// Show-ahead stream FIFO with ready backpressure or drop-on-full and a saturating drop counter.
// Pointers carry an extra wrap bit so full and empty can be told apart without a separate count.
module unidir_stream_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       valid,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam bit DROP = (DROP_ON_FULL != 0);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               rd_ptr, wr_ptr;
    logic                        full, empty, push, pop, drop;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign push  = in_valid & ~full;
    assign pop   = valid & out_ready;
    assign drop  = DROP & in_valid & full;

    assign in_ready = DROP ? 1'b1 : ~full;
    assign valid    = ~empty;
    assign level    = wr_ptr - rd_ptr;
    // Gate the head word so an empty FIFO never shows stale storage.
    assign data_out = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop && (drop_cnt != {CNT_W{1'b1}}))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible through valid.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr[AW-1:0]] <= data_in;
    end
endmodule
